// File: rtl/axis_frame_split_pkg.sv
// Shared types and derived-constant helpers for the AXI stream frame splitter.
package axis_frame_split_pkg;

  typedef enum logic [0:0] {
    ST_TAG,
    ST_SEG
  } state_e;

  // TAG_BYTES = TAG_WIDTH/8
  function automatic int unsigned tag_bytes(input int unsigned tag_width);
    return tag_width / 8;
  endfunction

  // PORT_WIDTH = $clog2(S_COUNT)
  function automatic int unsigned port_width(input int unsigned s_count);
    return (s_count > 1) ? $clog2(s_count) : 1;
  endfunction

endpackage

// File: rtl/axis_frame_split_skid.sv
// Two-entry register slice for one output port; ready comes straight from a flop.
module axis_skid_reg #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic                  i_s_last,
  input  logic                  i_s_user,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic                  o_m_last,
  output logic                  o_m_user
);

  logic [DATA_WIDTH+1:0] r_out;
  logic [DATA_WIDTH+1:0] r_skid;
  logic                  r_out_valid;
  logic                  r_skid_valid;
  logic                  w_in_xfer;
  logic                  w_out_free;

  assign o_s_ready  = !r_skid_valid;
  assign w_in_xfer  = i_s_valid && !r_skid_valid;
  assign w_out_free = !r_out_valid || i_m_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_in_xfer;
        if (w_in_xfer) r_out <= {i_s_data, i_s_last, i_s_user};
      end
    end else if (w_in_xfer) begin
      // Output is held by backpressure: park the byte in the second entry.
      r_skid       <= {i_s_data, i_s_last, i_s_user};
      r_skid_valid <= 1'b1;
    end
  end

  assign o_m_data  = r_out[DATA_WIDTH+1:2];
  assign o_m_last  = r_out[1];
  assign o_m_user  = r_out[0];
  assign o_m_valid = r_out_valid;

endmodule

// File: rtl/axis_frame_split.sv
// Splits one byte-stream frame into an optional tag plus S_COUNT consecutive sub-frames.
module axis_frame_split
  import axis_frame_split_pkg::*;
#(
  parameter int unsigned S_COUNT    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TAG_ENABLE = 1,
  parameter int unsigned TAG_WIDTH  = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tuser,
  output logic [S_COUNT*DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [S_COUNT-1:0]              m_axis_tvalid,
  input  logic [S_COUNT-1:0]              m_axis_tready,
  output logic [S_COUNT-1:0]              m_axis_tlast,
  output logic [S_COUNT-1:0]              m_axis_tuser,
  input  logic [S_COUNT*LEN_WIDTH-1:0]    seg_len,
  output logic [TAG_WIDTH-1:0]            m_tag,
  output logic                            m_tag_valid,
  output logic                            busy,
  output logic                            short_frame
);

  localparam int unsigned TagBytes  = tag_bytes(TAG_WIDTH);
  localparam int unsigned PortWidth = port_width(S_COUNT);
  localparam logic [PortWidth-1:0] LastPort = PortWidth'(S_COUNT - 1);
  localparam state_e StStart = (TAG_ENABLE != 0) ? ST_TAG : ST_SEG;

  state_e                       r_state;
  logic [PortWidth-1:0]         r_port;
  logic [PortWidth-1:0]         w_port;
  logic [LEN_WIDTH-1:0]         r_cnt;
  logic [LEN_WIDTH-1:0]         w_cnt_inc;
  logic [LEN_WIDTH-1:0]         w_cur_len;
  logic [S_COUNT*LEN_WIDTH-1:0] r_seg_len;
  logic [S_COUNT*LEN_WIDTH-1:0] w_seg_len;
  logic [TAG_WIDTH-1:0]         r_tag_sr;
  logic [TAG_WIDTH-1:0]         r_tag;
  logic [TAG_WIDTH-1:0]         w_tag_next;
  logic                         r_tag_valid;
  logic                         r_short;
  logic                         r_busy;
  logic                         r_rdy_en;
  logic                         w_xfer;
  logic                         w_last_port;
  logic                         w_seg_end;
  logic                         w_out_last;
  logic                         w_out_user;
  logic [S_COUNT-1:0]           w_skid_ready;
  logic [S_COUNT-1:0]           w_skid_valid;

  // The first byte of a frame sees the live lengths; later bytes use the latched copy.
  assign w_seg_len = r_busy ? r_seg_len : seg_len;

  // Effective port: skip forward over zero-length segments in the same cycle.
  always_comb begin
    w_port = LastPort;
    for (int p = S_COUNT - 2; p >= 0; p--) begin
      if (p >= int'(r_port) && w_seg_len[p*LEN_WIDTH +: LEN_WIDTH] != '0) begin
        w_port = PortWidth'(p);
      end
    end
  end

  assign w_cur_len   = w_seg_len[w_port*LEN_WIDTH +: LEN_WIDTH];
  assign w_last_port = (w_port == LastPort);
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_seg_end   = !w_last_port && (w_cnt_inc == w_cur_len);
  assign w_out_last  = s_axis_tlast || w_seg_end;
  assign w_out_user  = s_axis_tlast && (!w_last_port || s_axis_tuser);
  assign w_tag_next  = TAG_WIDTH'({r_tag_sr, s_axis_tdata});

  assign s_axis_tready = r_rdy_en && (r_state == ST_TAG || w_skid_ready[w_port]);
  assign w_xfer        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    w_skid_valid = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      w_skid_valid[i] = w_xfer && (r_state == ST_SEG) && (w_port == PortWidth'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StStart;
      r_port      <= '0;
      r_cnt       <= '0;
      r_seg_len   <= '0;
      r_tag_sr    <= '0;
      r_tag       <= '0;
      r_tag_valid <= 1'b0;
      r_short     <= 1'b0;
      r_busy      <= 1'b0;
      r_rdy_en    <= 1'b0;
    end else begin
      r_rdy_en    <= 1'b1;
      r_tag_valid <= 1'b0;
      r_short     <= 1'b0;
      if (w_xfer) begin
        if (!r_busy) r_seg_len <= seg_len;
        r_busy <= !s_axis_tlast;
        if (r_state == ST_TAG) begin
          if (s_axis_tlast) begin
            r_short <= 1'b1;
            r_cnt   <= '0;
          end else if (r_cnt == LEN_WIDTH'(TagBytes - 1)) begin
            r_tag       <= w_tag_next;
            r_tag_valid <= 1'b1;
            r_state     <= ST_SEG;
            r_port      <= '0;
            r_cnt       <= '0;
          end else begin
            r_tag_sr <= w_tag_next;
            r_cnt    <= w_cnt_inc;
          end
        end else if (s_axis_tlast) begin
          r_short <= !w_last_port;
          r_state <= StStart;
          r_port  <= '0;
          r_cnt   <= '0;
        end else if (w_seg_end) begin
          r_port <= w_port + 1'b1;
          r_cnt  <= '0;
        end else begin
          r_port <= w_port;
          r_cnt  <= w_cnt_inc;
        end
      end
    end
  end

  for (genvar g = 0; g < S_COUNT; g++) begin : g_port
    axis_skid_reg #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_s_data (s_axis_tdata),
      .i_s_valid(w_skid_valid[g]),
      .o_s_ready(w_skid_ready[g]),
      .i_s_last (w_out_last),
      .i_s_user (w_out_user),
      .o_m_data (m_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_m_valid(m_axis_tvalid[g]),
      .i_m_ready(m_axis_tready[g]),
      .o_m_last (m_axis_tlast[g]),
      .o_m_user (m_axis_tuser[g])
    );
  end

  assign m_tag       = r_tag;
  assign m_tag_valid = r_tag_valid;
  assign busy        = r_busy;
  assign short_frame = r_short;

endmodule

// File: tb/tb_axis_frame_split.sv
// Self-checking bench for axis_frame_split: frame-level reference model plus per-cycle monitor.
`timescale 1ns/1ps
module tb_axis_frame_split;

  localparam int S  = 4;
  localparam int LW = 16;
  localparam int TW = 16;
  localparam int TB = TW / 8;

  logic            clk;
  logic            rst;
  logic [7:0]      s_axis_tdata;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic            s_axis_tlast;
  logic            s_axis_tuser;
  logic [S*8-1:0]  m_axis_tdata;
  logic [S-1:0]    m_axis_tvalid;
  logic [S-1:0]    m_axis_tready;
  logic [S-1:0]    m_axis_tlast;
  logic [S-1:0]    m_axis_tuser;
  logic [S*LW-1:0] seg_len;
  logic [TW-1:0]   m_tag;
  logic            m_tag_valid;
  logic            busy;
  logic            short_frame;

  axis_frame_split #(
    .S_COUNT   (S),
    .DATA_WIDTH(8),
    .TAG_ENABLE(1),
    .TAG_WIDTH (TW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .seg_len      (seg_len),
    .m_tag        (m_tag),
    .m_tag_valid  (m_tag_valid),
    .busy         (busy),
    .short_frame  (short_frame)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [9:0]    exp_q [S][$];   // {data, last, user} per port
  logic [TW-1:0] tag_q [$];
  int seg_v [S];
  int cur_c;
  int ready_mode = 0;
  int n_sf_seen = 0;
  int stalls = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic set_seg(input int a0, input int a1, input int a2);
    seg_v[0] = a0;
    seg_v[1] = a1;
    seg_v[2] = a2;
    seg_v[3] = int'($urandom_range(0, 200));  // ignored field
    cur_c = 0;
    for (int i = 0; i < S; i++) begin
      seg_len[i*LW +: LW] = LW'(seg_v[i]);
      if (i < S - 1) cur_c += seg_v[i];
    end
  endtask

  task automatic mk_frame(input logic [TW-1:0] tag, input int n, input logic rnd,
                          output logic [7:0] fr[$]);
    fr = {};
    for (int i = TB - 1; i >= 0; i--) fr.push_back(tag[i*8 +: 8]);
    for (int i = 0; i < n; i++) fr.push_back(rnd ? 8'($urandom) : 8'(i));
  endtask

  // Frame-level model: payload index j lands on the port whose cumulative range holds it.
  task automatic model_frame(input logic [7:0] fr[$], input logic usr);
    int p_len;
    int cum [S];
    int p;
    logic [TW-1:0] tag;
    logic last, uo;
    p_len = fr.size() - TB;
    if (p_len <= 0) return;
    tag = '0;
    for (int i = 0; i < TB; i++) tag = (tag << 8) | TW'(fr[i]);
    tag_q.push_back(tag);
    cum[0] = 0;
    for (int i = 0; i < S - 1; i++) cum[i+1] = cum[i] + seg_v[i];
    for (int j = 0; j < p_len; j++) begin
      p = S - 1;
      for (int i = S - 2; i >= 0; i--) if (j < cum[i+1]) p = i;
      last = (j == p_len - 1) || (p < S - 1 && j == cum[p+1] - 1);
      uo   = (j == p_len - 1) && ((p < S - 1) ? 1'b1 : usr);
      exp_q[p].push_back({fr[TB+j], last, uo});
    end
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input logic usr, input int n_send,
                            input int vprob);
    int waited;
    for (int i = 0; i < n_send; i++) begin
      while (int'($urandom_range(99)) >= vprob) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_axis_tdata  = fr[i];
      s_axis_tlast  = (i == fr.size() - 1);
      s_axis_tuser  = usr && (i == fr.size() - 1);
      s_axis_tvalid = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!s_axis_tready) begin
        stalls++;
        waited++;
        if (waited > 2000) begin
          $display("FAIL input_stuck: tready low for %0d cycles", waited);
          $fatal(1);
        end
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic drain();
    int left;
    int t;
    t = 0;
    do begin
      @(negedge clk);
      left = tag_q.size();
      for (int p = 0; p < S; p++) left += exp_q[p].size();
      t++;
    end while (left != 0 && t < 3000);
    repeat (3) @(negedge clk);
    chk("drain", left, 0);
    @(posedge clk); #1;
  endtask

  // Random or fixed backpressure on the outputs.
  initial begin
    m_axis_tready = '1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       m_axis_tready = '1;
        1:       m_axis_tready = S'($urandom);
        default: m_axis_tready = '0;
      endcase
    end
  end

  // Per-cycle compare process.
  int         k;
  logic       e_tv, e_sf, e_busy;
  logic [S-1:0] pv, pr;
  logic [9:0] pf [S];
  logic [9:0] f;
  always @(negedge clk) begin
    if (rst) begin
      k = 0; e_tv = 0; e_sf = 0; e_busy = 0; pv = '0; pr = '0;
    end else begin
      chk("m_tag_valid", m_tag_valid, e_tv);
      chk("short_frame", short_frame, e_sf);
      chk("busy", busy, e_busy);
      if (short_frame) n_sf_seen++;
      if (m_tag_valid) begin
        chk("tag_expected", tag_q.size() != 0, 1);
        if (tag_q.size() != 0) chk("m_tag", m_tag, tag_q.pop_front());
      end
      for (int p = 0; p < S; p++) begin
        f = {m_axis_tdata[p*8 +: 8], m_axis_tlast[p], m_axis_tuser[p]};
        if (pv[p] && !pr[p]) chk($sformatf("hold_p%0d", p), {m_axis_tvalid[p], f}, {1'b1, pf[p]});
        if (m_axis_tvalid[p] && m_axis_tready[p]) begin
          chk($sformatf("expected_p%0d", p), exp_q[p].size() != 0, 1);
          if (exp_q[p].size() != 0) chk($sformatf("out_p%0d", p), f, exp_q[p].pop_front());
        end
        pv[p] = m_axis_tvalid[p];
        pr[p] = m_axis_tready[p];
        pf[p] = f;
      end
      e_tv = 0;
      e_sf = 0;
      if (s_axis_tvalid && s_axis_tready) begin
        if (k == TB - 1 && !s_axis_tlast) e_tv = 1;
        if (s_axis_tlast) begin
          e_sf   = ((k - TB) < cur_c);
          e_busy = 0;
          k      = 0;
        end else begin
          e_busy = 1;
          k++;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [7:0] fr [$];
  int sf0;
  int n;
  logic usr;
  initial begin
    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tuser = 0;
    set_seg(1, 2, 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_tag", m_tag, 0);
    chk("rst_tag_valid", m_tag_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_short", short_frame, 0);
    chk("rst_tready", s_axis_tready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("tready_wait", s_axis_tready, 0);
    @(negedge clk);
    chk("tready_rise", s_axis_tready, 1);
    @(posedge clk); #1;

    // Basic split with tag
    set_seg(1, 2, 3);
    mk_frame(16'hABCD, 10, 1'b0, fr);
    model_frame(fr, 1'b0);
    chk("model1_p0_n", exp_q[0].size(), 1);
    chk("model1_p1_n", exp_q[1].size(), 2);
    chk("model1_p2_n", exp_q[2].size(), 3);
    chk("model1_p3_n", exp_q[3].size(), 4);
    chk("model1_p3_tail", exp_q[3][3], {8'd9, 1'b1, 1'b0});
    sf0 = n_sf_seen;
    send_frame(fr, 1'b0, fr.size(), 100);
    drain();
    chk("t1_tag", m_tag, 16'hABCD);
    chk("t1_short", n_sf_seen - sf0, 0);

    // tuser only on the final byte of the last port
    mk_frame(16'hABCD, 10, 1'b0, fr);
    model_frame(fr, 1'b1);
    chk("model2_p3_tail", exp_q[3][3], {8'd9, 1'b1, 1'b1});
    chk("model2_p2_tail", exp_q[2][2], {8'd5, 1'b1, 1'b0});
    send_frame(fr, 1'b1, fr.size(), 100);
    drain();

    // Zero-length segment skipped without bubbles
    set_seg(2, 0, 2);
    mk_frame(16'hABCD, 6, 1'b0, fr);
    model_frame(fr, 1'b0);
    chk("model3_p1_n", exp_q[1].size(), 0);
    chk("model3_p2_head", exp_q[2][0], {8'd2, 1'b0, 1'b0});
    stalls = 0;
    send_frame(fr, 1'b0, fr.size(), 100);
    chk("t3_stalls", stalls, 0);
    drain();

    // Short frame
    set_seg(4, 4, 4);
    mk_frame(16'hABCD, 5, 1'b0, fr);
    model_frame(fr, 1'b0);
    chk("model4_p1", exp_q[1][0], {8'd4, 1'b1, 1'b1});
    chk("model4_p2_n", exp_q[2].size(), 0);
    sf0 = n_sf_seen;
    send_frame(fr, 1'b0, fr.size(), 100);
    drain();
    chk("t4_short", n_sf_seen - sf0, 1);

    // tlast on the first tag byte, then a normal frame
    mk_frame(16'h1234, 3, 1'b0, fr);
    while (fr.size() > 1) void'(fr.pop_back());
    model_frame(fr, 1'b0);
    sf0 = n_sf_seen;
    send_frame(fr, 1'b0, fr.size(), 100);
    drain();
    chk("t5_short", n_sf_seen - sf0, 1);
    chk("t5_tag_kept", m_tag, 16'hABCD);
    set_seg(1, 1, 1);
    mk_frame(16'h1234, 3, 1'b0, fr);
    model_frame(fr, 1'b0);
    send_frame(fr, 1'b0, fr.size(), 100);
    drain();
    chk("t5_tag_new", m_tag, 16'h1234);

    // Random traffic with random backpressure
    ready_mode = 1;
    for (int f_i = 0; f_i < 200; f_i++) begin
      set_seg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      n = int'($urandom_range(0, 14));
      mk_frame(TW'($urandom), n, 1'b1, fr);
      if ($urandom_range(9) == 0) begin
        n = int'($urandom_range(1, TB));
        while (fr.size() > n) void'(fr.pop_back());
      end
      usr = 1'($urandom);
      model_frame(fr, usr);
      send_frame(fr, usr, fr.size(), 70);
    end
    ready_mode = 0;
    drain();

    // Reset in the middle of a frame
    ready_mode = 2;
    set_seg(8, 1, 1);
    mk_frame(16'h5555, 6, 1'b0, fr);
    model_frame(fr, 1'b0);
    send_frame(fr, 1'b0, TB + 2, 100);
    @(negedge clk);
    chk("pre_rst_valid", m_axis_tvalid[0], 1);
    chk("pre_rst_busy", busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_busy", busy, 0);
    for (int p = 0; p < S; p++) exp_q[p].delete();
    tag_q.delete();
    ready_mode = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    set_seg(1, 1, 1);
    mk_frame(16'h0F0F, 4, 1'b0, fr);
    model_frame(fr, 1'b0);
    send_frame(fr, 1'b0, fr.size(), 100);
    drain();
    chk("post_rst_tag", m_tag, 16'h0F0F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_frame_split.md
# axis_frame_split

Receive-side counterpart of the frame joiner: accepts one 8-bit AXI stream frame, strips an optional big-endian tag header, and cuts the remaining payload into S_COUNT consecutive sub-frames. Segment lengths come from a configuration vector. Sub-frame i goes out on master port i, with tlast on its final byte. It sits after a link receiver and in front of per-channel consumers, undoing what the joiner built on the transmit side.

## Interface
- S_COUNT, 4, number of output ports (2..16)
- DATA_WIDTH, 8, data width; fixed at 8 (byte stream)
- TAG_ENABLE, 1, 1 = first TAG_WIDTH/8 bytes of each frame are the tag
- TAG_WIDTH, 16, tag width; must be a multiple of 8
- LEN_WIDTH, 16, width of each segment length field
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  8  input frame data
- s_axis_tvalid / s_axis_tready  in / out  1 / 1  input handshake; tready is registered
- s_axis_tlast, s_axis_tuser  in  1, 1  end of frame; error flag
- m_axis_tdata  out  S_COUNT*8  per-port data, port i at bits [8i+7:8i]
- m_axis_tvalid, m_axis_tready  out, in  S_COUNT, S_COUNT  per-port handshake
- m_axis_tlast, m_axis_tuser  out  S_COUNT, S_COUNT  per-port end of segment; error flag
- seg_len  in  S_COUNT*LEN_WIDTH  byte count for segments 0..S_COUNT-2; field S_COUNT-1 is ignored
- m_tag  out  TAG_WIDTH  tag of the current frame; holds until the next tag completes
- m_tag_valid  out  1  one-cycle pulse when m_tag is updated
- busy  out  1  a frame is in progress
- short_frame  out  1  one-cycle pulse when a frame ends early

## Operation
- Byte transfer: s_axis_tvalid && s_axis_tready.
- State TAG (entered on reset only if TAG_ENABLE=1; otherwise reset enters SEG):
  - Bytes shift into the tag register MSB first.
  - After TAG_WIDTH/8 bytes: m_tag updates, m_tag_valid pulses, state goes to SEG with port=0.
- seg_len is latched on the first byte of each frame. It is sampled when that byte transfers, tag byte or payload.
- State SEG:
  - Each byte goes to output port `port`, and the byte counter increments.
  - For port < S_COUNT-1, the byte that brings the count to seg_len[port] gets m_tlast=1. Then port increments and the counter clears.
  - A zero-length segment emits nothing on that port, and the port is skipped in the same cycle. Several consecutive zero-length segments are all skipped.
  - The last port takes all remaining bytes until s_axis_tlast. Its m_tlast=1 and m_tuser=s_axis_tuser.
- Frame end: after s_axis_tlast transfers, the state returns to TAG (or SEG with port=0 when TAG_ENABLE=0). busy falls.
- Short frame, where s_axis_tlast arrives before the last port is reached:
  - The current port's byte goes out with m_tlast=1 and m_tuser=1.
  - Later ports get no frame.
  - short_frame pulses and the state returns to the start.
- s_axis_tlast during TAG: the frame is dropped, m_tag is not updated, short_frame pulses, and no output is driven.
- Each output has a two-entry skid register. Backpressure on one port stalls only that port's path. The input stalls when the current port's skid is full.
- Earlier ports may still be draining while a later port is active.

## Timing
- Reset values: all m_axis_tvalid=0, m_tlast=0, m_tuser=0, m_tag=0, m_tag_valid=0, busy=0, short_frame=0, s_axis_tready=0. The internal counter and port index are 0.
- s_axis_tready rises the cycle after rst deasserts.
- Latency: a byte accepted in cycle N is valid on its port in cycle N+1, provided that port's output register is empty.
- Full throughput: one byte per cycle while the active port is ready, including across segment boundaries with zero bubble cycles.
- m_tag_valid pulses in the cycle after the last tag byte transfers.
- short_frame pulses in the cycle after the offending tlast transfers.
- busy is high from the cycle after the first byte transfers until the cycle after tlast transfers.
- Once valid, m_axis_tvalid[i] and its data/tlast/tuser stay stable until m_axis_tready[i] is high.
- Reset mid-frame: skid contents and the partial frame are discarded immediately. No tlast is emitted. The next byte is treated as a frame start.
- Counter width is LEN_WIDTH. A segment length can never exceed 2^LEN_WIDTH-1, so the counter does not wrap.

## Structure
- Shared package holds:
  - State encoding: ST_TAG, ST_SEG.
  - Derived constants: TAG_BYTES = TAG_WIDTH/8, PORT_WIDTH = $clog2(S_COUNT).
- Sub-module axis_skid_reg: the per-output two-entry register slice carrying data/last/user. It is instantiated S_COUNT times.
- Top level holds the FSM, tag shifter, counter, port index and demux.

## Test plan
- S_COUNT=4, tag 0xABCD, seg_len {x,3,2,1}, 10-byte payload 0..9 -> m_tag=0xABCD with one pulse; port0 gets 0; port1 gets 1,2; port2 gets 3,4,5; port3 gets 6..9; each tlast on its final byte; no short_frame.
- Same frame with s_axis_tuser=1 on tlast -> only port3's last byte has tuser=1.
- seg_len {x,2,0,2}, 6-byte payload -> port0 2 bytes, port1 no frame, port2 2 bytes, port3 2 bytes; no bubble cycles.
- seg_len {x,4,4,4}, 5-byte payload -> port0 4 bytes; port1 byte 4 with tlast=1, tuser=1; short_frame pulses; ports 2 and 3 idle.
- tlast on the 1st tag byte -> no outputs, m_tag unchanged, short_frame pulses; the next frame parses correctly.
- Random m_axis_tready on all ports plus random s_axis_tvalid over 200 frames -> per-port byte streams match the model; no data loss or duplication; rst asserted mid-frame leaves all valids 0 on the next cycle.
